efuse_prog_ctrl: RTL and testbench

EFUSE_PROG_CTRL -- requirements
Module: efuse_prog_ctrl

---
 rtl/efuse_prog_ctrl.sv | 153 +++++++++++++++
 tb/tb_efuse_prog_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/efuse_prog_ctrl.sv
`timescale 1ns/1ps
// eFuse program/read sequencer: walks one NW-bit word of the macro bit by bit,
// producing setup/strobe/hold timing for bits to blow and for every read bit.
module efuse_prog_ctrl #(
  parameter  int NBITS = 256,
  parameter  int NW    = 64,
  parameter  int TW    = 10,
  localparam int WSEL  = NBITS / NW,
  localparam int SW    = (WSEL > 1) ? $clog2(WSEL) : 1,
  localparam int AW    = $clog2(NBITS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] rg_efuse_tpgm,
  input  logic [TW-1:0] rg_efuse_trd,
  input  logic          cmd_mode,
  input  logic [SW-1:0] cmd_sel,
  input  logic [NW-1:0] cmd_data,
  input  logic          cmd_start,
  input  logic          efuse_dout_i,
  output logic          cmd_done,
  output logic          busy,
  output logic          cmd_err,
  output logic [NW-1:0] rd_data,
  output logic          efuse_pgmen_o,
  output logic          efuse_rden_o,
  output logic          efuse_aen_o,
  output logic [AW-1:0] efuse_addr_o
);

  localparam int BW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    SKIP,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [NW-1:0] data_q, data_d;
  logic [TW-1:0] t_q, t_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [NW-1:0] rd_data_q, rd_data_d;
  logic          cmd_err_q, cmd_err_d;

  logic [TW-1:0] t_req;
  logic [BW-1:0] bit_inc;
  logic          last_bit;
  logic          strobe_last;
  logic          in_access;

  assign t_req       = cmd_mode ? rg_efuse_trd : rg_efuse_tpgm;
  assign bit_inc     = bit_q + BW'(1);
  assign last_bit    = (bit_q == BW'(NW - 1));
  assign strobe_last = (cnt_q == (t_q - TW'(1)));

  // Zero bits of a program word are passed over in a single SKIP cycle.
  function automatic state_e bit_entry(input logic mode, input logic bit_val);
    return (!mode && !bit_val) ? SKIP : SETUP;
  endfunction

  always_comb begin
    // NOTE: every next-state signal is defaulted first so no path through the case infers a latch.
    state_d   = state_q;
    mode_d    = mode_q;
    sel_d     = sel_q;
    data_d    = data_q;
    t_d       = t_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    rd_data_d = rd_data_q;
    cmd_err_d = cmd_start && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          mode_d  = cmd_mode;
          sel_d   = cmd_sel;
          data_d  = cmd_data;
          t_d     = (t_req == '0) ? TW'(1) : t_req;
          bit_d   = '0;
          cnt_d   = '0;
          state_d = bit_entry(cmd_mode, cmd_data[0]);
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = STROBE;
      end
      STROBE: begin
        if (strobe_last) begin
          state_d = HOLD;
          if (mode_q) rd_data_d[bit_q] = efuse_dout_i;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      HOLD, SKIP: begin
        if (last_bit) begin
          state_d = DONE;
        end else begin
          bit_d   = bit_inc;
          state_d = bit_entry(mode_q, data_q[bit_inc]);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      sel_q     <= '0;
      data_q    <= '0;
      t_q       <= TW'(1);
      cnt_q     <= '0;
      bit_q     <= '0;
      rd_data_q <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      t_q       <= t_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      rd_data_q <= rd_data_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // Macro controls decode straight from state so reset drops them without waiting for a clock.
  assign in_access     = (state_q inside {SETUP, STROBE, HOLD});
  assign busy          = (state_q != IDLE);
  assign cmd_done      = (state_q == DONE);
  assign cmd_err       = cmd_err_q;
  assign rd_data       = rd_data_q;
  assign efuse_pgmen_o = in_access && !mode_q;
  assign efuse_rden_o  = in_access && mode_q;
  assign efuse_aen_o   = (state_q == STROBE);
  assign efuse_addr_o  = in_access ? (AW'(sel_q) * AW'(NW) + AW'(bit_q)) : '0;

endmodule

// File: tb/tb_efuse_prog_ctrl.sv
`timescale 1ns/1ps
// Directed bench for efuse_prog_ctrl: program/read sequencing, rejection of
// overlapping requests and asynchronous reset mid-strobe.
module tb_efuse_prog_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  rg_efuse_tpgm;
  logic [9:0]  rg_efuse_trd;
  logic        cmd_mode;
  logic [1:0]  cmd_sel;
  logic [63:0] cmd_data;
  logic        cmd_start;
  logic        efuse_dout_i;
  logic        cmd_done;
  logic        busy;
  logic        cmd_err;
  logic [63:0] rd_data;
  logic        efuse_pgmen_o;
  logic        efuse_rden_o;
  logic        efuse_aen_o;
  logic [7:0]  efuse_addr_o;

  efuse_prog_ctrl #(.NBITS(256), .NW(64), .TW(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .rg_efuse_tpgm (rg_efuse_tpgm),
    .rg_efuse_trd  (rg_efuse_trd),
    .cmd_mode      (cmd_mode),
    .cmd_sel       (cmd_sel),
    .cmd_data      (cmd_data),
    .cmd_start     (cmd_start),
    .efuse_dout_i  (efuse_dout_i),
    .cmd_done      (cmd_done),
    .busy          (busy),
    .cmd_err       (cmd_err),
    .rd_data       (rd_data),
    .efuse_pgmen_o (efuse_pgmen_o),
    .efuse_rden_o  (efuse_rden_o),
    .efuse_aen_o   (efuse_aen_o),
    .efuse_addr_o  (efuse_addr_o)
  );

  always #5 clk = ~clk;

  // Macro model: each fuse reads back as the LSB of its address.
  assign efuse_dout_i = efuse_addr_o[0];

  int n_tests = 0;
  int n_fail  = 0;

  int       done_cyc, done_cnt, err_cnt, pgmen_cnt, rden_cnt, overlap, busy_err;
  int       first_pgmen, n_str;
  bit       timed_out;
  logic [7:0] s_addr [64];
  int       s_len  [64];

  task automatic start_cmd(input logic mode, input logic [1:0] sel, input logic [63:0] data,
                           input logic [9:0] tpgm, input logic [9:0] trd);
    @(negedge clk);
    cmd_mode      = mode;
    cmd_sel       = sel;
    cmd_data      = data;
    rg_efuse_tpgm = tpgm;
    rg_efuse_trd  = trd;
    cmd_start     = 1'b1;
  endtask

  // Cycle 0 is the first cycle after acceptance; runs 3 cycles past cmd_done.
  task automatic watch(input int budget, input bit inj_strobe, input bit inj_done);
    bit prev_aen  = 1'b0;
    bit done_seen = 1'b0;
    bit inj_s     = 1'b0;
    int tail      = 0;
    done_cyc = -1; done_cnt = 0; err_cnt = 0; pgmen_cnt = 0; rden_cnt = 0;
    overlap = 0; busy_err = 0; first_pgmen = -1; n_str = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (busy !== !done_seen) busy_err++;
      if (cmd_err) err_cnt++;
      if (cmd_done) done_cnt++;
      if (efuse_pgmen_o) begin
        pgmen_cnt++;
        if (first_pgmen < 0) first_pgmen = c;
      end
      if (efuse_rden_o) rden_cnt++;
      if (efuse_pgmen_o && efuse_rden_o) overlap++;
      if (efuse_aen_o) begin
        if (!prev_aen && n_str < 64) begin
          s_addr[n_str] = efuse_addr_o;
          s_len[n_str]  = 1;
          n_str++;
        end else if (prev_aen && n_str > 0) begin
          s_len[n_str-1]++;
        end
      end
      prev_aen  = efuse_aen_o;
      cmd_start = 1'b0;
      if ((inj_strobe && efuse_aen_o && !inj_s) || (inj_done && cmd_done)) begin
        inj_s         = 1'b1;
        cmd_start     = 1'b1;
        cmd_mode      = ~cmd_mode;
        cmd_data      = ~cmd_data;
        cmd_sel       = cmd_sel + 2'd1;
        rg_efuse_tpgm = 10'd1;
        rg_efuse_trd  = 10'd1;
      end
      if (cmd_done && !done_seen) begin
        done_seen = 1'b1;
        done_cyc  = c;
      end else if (done_seen) begin
        tail++;
        if (tail >= 3) break;
      end
    end
    cmd_start = 1'b0;
    timed_out = !done_seen;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_start = 1'b0; cmd_mode = 1'b0; cmd_sel = '0; cmd_data = '0;
    rg_efuse_tpgm = '0; rg_efuse_trd = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (cmd_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", cmd_done); end
    n_tests++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", cmd_err); end
    n_tests++; if ({efuse_pgmen_o, efuse_rden_o, efuse_aen_o} !== 3'b000) begin
      n_fail++; $display("FAIL rst_ctl: got %b want 000", {efuse_pgmen_o, efuse_rden_o, efuse_aen_o}); end
    n_tests++; if (efuse_addr_o !== 8'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", efuse_addr_o); end
    n_tests++; if (rd_data !== 64'd0) begin n_fail++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    rst = 1'b0;
  endtask

  task automatic test_prog_f1;
    int exp_a [5] = '{0, 4, 5, 6, 7};
    int bad = 0;
    start_cmd(1'b0, 2'd0, 64'hF1, 10'd5, 10'd3);
    watch(400, 1'b0, 1'b0);
    for (int k = 0; k < 5 && k < n_str; k++)
      if (s_addr[k] !== 8'(exp_a[k]) || s_len[k] != 5) bad++;
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL f1_timeout: got no cmd_done want done"); end
    n_tests++; if (done_cyc != 94) begin n_fail++; $display("FAIL f1_done_cyc: got %0d want 94", done_cyc); end
    n_tests++; if (n_str != 5) begin n_fail++; $display("FAIL f1_strobes: got %0d want 5", n_str); end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL f1_strobe_addr_len: got %0d bad want 0", bad); end
    n_tests++; if (pgmen_cnt != 35) begin n_fail++; $display("FAIL f1_pgmen_cycles: got %0d want 35", pgmen_cnt); end
    n_tests++; if (rden_cnt != 0) begin n_fail++; $display("FAIL f1_rden: got %0d want 0", rden_cnt); end
    n_tests++; if (busy_err != 0) begin n_fail++; $display("FAIL f1_busy: got %0d bad cycles want 0", busy_err); end
  endtask

  task automatic test_prog_msb;
    start_cmd(1'b0, 2'd3, 64'h8000_0000_0000_0000, 10'd5, 10'd3);
    watch(400, 1'b0, 1'b0);
    n_tests++; if (done_cyc != 70) begin n_fail++; $display("FAIL msb_done_cyc: got %0d want 70", done_cyc); end
    n_tests++; if (n_str != 1 || s_addr[0] !== 8'd255 || s_len[0] != 5) begin
      n_fail++; $display("FAIL msb_strobe: got n=%0d addr=%0d len=%0d want n=1 addr=255 len=5", n_str, s_addr[0], s_len[0]); end
    n_tests++; if (first_pgmen != 63 || pgmen_cnt != 7) begin
      n_fail++; $display("FAIL msb_pgmen: got first=%0d cnt=%0d want first=63 cnt=7", first_pgmen, pgmen_cnt); end
  endtask

  task automatic test_read;
    int bad = 0;
    start_cmd(1'b1, 2'd1, 64'h0, 10'd9, 10'd2);
    watch(600, 1'b0, 1'b0);
    for (int k = 0; k < 64 && k < n_str; k++)
      if (s_addr[k] !== 8'(64 + k) || s_len[k] != 2) bad++;
    n_tests++; if (done_cyc != 256) begin n_fail++; $display("FAIL rd_done_cyc: got %0d want 256", done_cyc); end
    n_tests++; if (rd_data !== 64'hAAAA_AAAA_AAAA_AAAA) begin
      n_fail++; $display("FAIL rd_data: got %h want aaaaaaaaaaaaaaaa", rd_data); end
    n_tests++; if (rden_cnt != 256) begin n_fail++; $display("FAIL rd_rden_cycles: got %0d want 256", rden_cnt); end
    n_tests++; if (pgmen_cnt != 0 || overlap != 0) begin
      n_fail++; $display("FAIL rd_pgmen: got pgmen=%0d overlap=%0d want 0 0", pgmen_cnt, overlap); end
    n_tests++; if (n_str != 64 || bad != 0) begin
      n_fail++; $display("FAIL rd_strobes: got n=%0d bad=%0d want n=64 bad=0", n_str, bad); end
  endtask

  task automatic test_prog_zero;
    start_cmd(1'b0, 2'd2, 64'h0, 10'd5, 10'd2);
    watch(400, 1'b0, 1'b0);
    n_tests++; if (done_cyc != 64) begin n_fail++; $display("FAIL zero_done_cyc: got %0d want 64", done_cyc); end
    n_tests++; if (n_str != 0 || pgmen_cnt != 0) begin
      n_fail++; $display("FAIL zero_strobes: got n=%0d pgmen=%0d want 0 0", n_str, pgmen_cnt); end
    n_tests++; if (rd_data !== 64'hAAAA_AAAA_AAAA_AAAA) begin
      n_fail++; $display("FAIL zero_rd_hold: got %h want aaaaaaaaaaaaaaaa", rd_data); end
  endtask

  task automatic test_tpgm_zero;
    start_cmd(1'b0, 2'd0, 64'h1, 10'd0, 10'd0);
    watch(400, 1'b0, 1'b0);
    n_tests++; if (done_cyc != 66) begin n_fail++; $display("FAIL t0_done_cyc: got %0d want 66", done_cyc); end
    n_tests++; if (n_str != 1 || s_addr[0] !== 8'd0 || s_len[0] != 1) begin
      n_fail++; $display("FAIL t0_strobe: got n=%0d addr=%0d len=%0d want n=1 addr=0 len=1", n_str, s_addr[0], s_len[0]); end
  endtask

  task automatic test_back_to_back;
    int exp_a [5] = '{0, 4, 5, 6, 7};
    int bad = 0;
    start_cmd(1'b0, 2'd0, 64'hF1, 10'd5, 10'd3);
    watch(400, 1'b1, 1'b1);
    for (int k = 0; k < 5 && k < n_str; k++)
      if (s_addr[k] !== 8'(exp_a[k]) || s_len[k] != 5) bad++;
    n_tests++; if (err_cnt != 2) begin n_fail++; $display("FAIL b2b_err_pulses: got %0d want 2", err_cnt); end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL b2b_done_pulses: got %0d want 1", done_cnt); end
    n_tests++; if (done_cyc != 94) begin n_fail++; $display("FAIL b2b_done_cyc: got %0d want 94", done_cyc); end
    n_tests++; if (n_str != 5 || bad != 0 || rden_cnt != 0) begin
      n_fail++; $display("FAIL b2b_unchanged: got n=%0d bad=%0d rden=%0d want 5 0 0", n_str, bad, rden_cnt); end
    n_tests++; if (busy_err != 0) begin n_fail++; $display("FAIL b2b_busy: got %0d bad cycles want 0", busy_err); end
  endtask

  task automatic test_reset_mid;
    bit found = 1'b0;
    start_cmd(1'b0, 2'd0, 64'hF1, 10'd5, 10'd3);
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      cmd_start = 1'b0;
      if (efuse_aen_o) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL mid_no_strobe: got no aen want aen"); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({efuse_aen_o, efuse_pgmen_o, busy} !== 3'b000) begin
      n_fail++; $display("FAIL mid_rst_ctl: got %b want 000", {efuse_aen_o, efuse_pgmen_o, busy}); end
    n_tests++; if (efuse_addr_o !== 8'd0) begin n_fail++; $display("FAIL mid_rst_addr: got %0d want 0", efuse_addr_o); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    watch(150, 1'b0, 1'b0);
    n_tests++; if (done_cnt != 0 || pgmen_cnt != 0 || n_str != 0) begin
      n_fail++; $display("FAIL mid_abandon: got done=%0d pgmen=%0d strobes=%0d want 0 0 0", done_cnt, pgmen_cnt, n_str); end
    start_cmd(1'b0, 2'd1, 64'h3, 10'd4, 10'd3);
    watch(400, 1'b0, 1'b0);
    n_tests++; if (done_cyc != 74 || n_str != 2 || s_addr[0] !== 8'd64 || s_addr[1] !== 8'd65) begin
      n_fail++; $display("FAIL mid_next_cmd: got done=%0d n=%0d a0=%0d a1=%0d want 74 2 64 65",
                         done_cyc, n_str, s_addr[0], s_addr[1]); end
  endtask

  initial begin
    test_reset();
    test_prog_f1();
    test_prog_msb();
    test_read();
    test_prog_zero();
    test_tpgm_zero();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
